// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
// Elaboration-time arithmetic for group and stage partitioning.
// The per-stage payload struct is declared inside cla_pipe_adder because its
// field widths follow the WIDTH parameter of each instance.
// Optional feature macro used by the design: CLA_SUB_EN.

package cla_pkg;

    // Ceiling log2, usable in constant expressions (returns 0 for values <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Number of GROUP-bit lookahead groups covering a WIDTH-bit operand.
    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

    // Groups resolved by each pipeline stage.
    function automatic int gps(input int width, input int group, input int stages);
        return (width / group) / stages;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// cla_group: combinational GROUP-bit carry-lookahead block.
// Produces the group sum for a given carry-in plus the group generate and
// propagate terms, so the caller can chain groups with a second lookahead
// level. No configuration macros affect this file.

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             g,
    output logic             p,
    output logic             c_out
);

    logic [GROUP-1:0] gi;
    logic [GROUP-1:0] pi;
    logic [GROUP-1:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    // Carry into every bit as a flat sum of products over the lower bits.
    always_comb begin : bit_carries
        logic acc;
        logic pp;
        // NOTE: every variable gets a default before any conditional or loop
        // assignment so no path can leave it unassigned and infer a latch.
        acc  = 1'b0;
        pp   = 1'b0;
        c    = '0;
        c[0] = c_in;
        for (int i = 1; i < GROUP; i++) begin
            acc = gi[i-1];
            pp  = pi[i-1];
            for (int j = i - 2; j >= 0; j--) begin
                acc = acc | (pp & gi[j]);
                pp  = pp & pi[j];
            end
            c[i] = acc | (pp & c_in);
        end
    end

    // Group generate: some bit generates and every higher bit propagates it.
    always_comb begin : group_generate
        logic acc;
        logic pp;
        acc = gi[GROUP-1];
        pp  = pi[GROUP-1];
        for (int j = GROUP - 2; j >= 0; j--) begin
            acc = acc | (pp & gi[j]);
            pp  = pp & pi[j];
        end
        g = acc;
    end

    assign p     = &pi;
    assign s     = pi ^ c;
    assign c_out = g | (p & c_in);

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: parametrised pipelined carry-lookahead adder with
// valid/ready handshakes on both sides.
// Stage k resolves lookahead groups k*GPS .. (k+1)*GPS-1; completed sum bits,
// the running carry and the still-unused operand bits ride in the stage
// registers. Latency is STAGES cycles; bubbles collapse under backpressure.
// Optional feature: define CLA_SUB_EN to add a 'sub' input that selects
// a - b (cin ignored, cout = no borrow); 'sub' travels with its operands.

module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG    = ngroups(WIDTH, GROUP);
    localparam int GPS_N = gps(WIDTH, GROUP, STAGES);

    // Everything one in-flight addition needs between stages.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
`ifdef CLA_SUB_EN
        logic             sub;
`endif
    } payload_t;

    payload_t         stage_q  [STAGES];
    payload_t         stage_d  [STAGES];
    payload_t         stage_in [STAGES];
    logic             valid_q  [STAGES];
    logic             valid_d  [STAGES];
    logic             in_vld   [STAGES];
    logic             load     [STAGES];

    logic             grp_cin  [NG];
    logic [GROUP-1:0] grp_s    [NG];
    logic             grp_g    [NG];
    logic             grp_p    [NG];
    logic             grp_co   [NG];

    // Operand source of each stage: the ports for stage 0, the previous register otherwise.
    always_comb begin : stage_sources
        stage_in[0].a     = a;
        stage_in[0].b     = b;
        stage_in[0].sum   = '0;
`ifdef CLA_SUB_EN
        stage_in[0].sub   = sub;
        stage_in[0].carry = sub ? 1'b1 : cin;
`else
        stage_in[0].carry = cin;
`endif
        in_vld[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
            in_vld[k]   = valid_q[k-1];
        end
    end

    // One lookahead block per group, fed from the stage that owns it.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int K = gi / GPS_N;
        logic [GROUP-1:0] b_raw;
        logic [GROUP-1:0] b_eff;

        assign b_raw = stage_in[K].b[gi*GROUP +: GROUP];
`ifdef CLA_SUB_EN
        assign b_eff = stage_in[K].sub ? ~b_raw : b_raw;
`else
        assign b_eff = b_raw;
`endif

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a     (stage_in[K].a[gi*GROUP +: GROUP]),
            .b     (b_eff),
            .c_in  (grp_cin[gi]),
            .s     (grp_s[gi]),
            .g     (grp_g[gi]),
            .p     (grp_p[gi]),
            .c_out (grp_co[gi])
        );
    end

    // Second-level lookahead: carry into each group of a stage from group G/P terms.
    always_comb begin : group_carries
        logic c;
        c = 1'b0;
        for (int n = 0; n < NG; n++) begin
            grp_cin[n] = 1'b0;
        end
        for (int k = 0; k < STAGES; k++) begin
            c = stage_in[k].carry;
            for (int j = 0; j < GPS_N; j++) begin
                grp_cin[k*GPS_N + j] = c;
                c = grp_g[k*GPS_N + j] | (grp_p[k*GPS_N + j] & c);
            end
        end
    end

    // Load enables ripple back from the consumer: a stage loads when it is empty
    // or its occupant moves on this cycle.
    always_comb begin : load_chain
        logic nxt;
        nxt              = !valid_q[STAGES-1] || out_ready;
        load[STAGES-1]   = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt     = !valid_q[k] || nxt;
            load[k] = nxt;
        end
    end

    // Next stage contents: merge this stage's resolved groups into the payload.
    always_comb begin : stage_next
        payload_t res;
        res = '0;
        for (int k = 0; k < STAGES; k++) begin
            res = stage_in[k];
            for (int j = 0; j < GPS_N; j++) begin
                res.sum[(k*GPS_N + j)*GROUP +: GROUP] = grp_s[k*GPS_N + j];
            end
            res.carry = grp_co[(k+1)*GPS_N - 1];
            // Data registers only move when real data arrives, so sum/cout stay
            // put until the last stage takes a new result.
            stage_d[k] = (load[k] && in_vld[k]) ? res : stage_q[k];
            valid_d[k] = load[k] ? in_vld[k] : valid_q[k];
        end
    end

    // Stage registers; reset empties the pipe and discards in-flight results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the stage registers are flops, not a memory array, so they
            // are cleared too; that makes sum/cout read 0 straight out of reset.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every stage samples the
            // pre-edge value of its predecessor, independent of statement order.
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = stage_q[STAGES-1].sum;
    assign cout      = stage_q[STAGES-1].carry;

endmodule
